// File: rtl/inst_queue.sv
// inst_queue -- instruction queue between the fetch and decode stages.
//
// Fetch pushes {instruction, pc} pairs and decode pops them. The queue is a
// circular buffer of 2^DEPTH_LOG2 entries with head/tail pointers and an
// occupancy count. The head entry is shown combinationally. When the queue
// is empty, the head outputs read as zero, so decode sees opcode 0.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset (clears pointers and count)
//   iq_flush     drop every entry at the next edge (only with IQ_FLUSH_EN)
//   fetch_valid  fetch offers an instruction this cycle
//   fetch_inst   offered instruction word
//   fetch_pc     address of the offered instruction
//   fetch_ready  the queue can accept an instruction this cycle
//   inst_in      head instruction word (0 when empty)
//   inst_pc      head instruction address (0 when empty)
//   inst_stall   the queue is empty and the head outputs are invalid
//   inst_enable  decode consumes the head this cycle
//   iq_count     number of valid entries
//
// Optional feature
//   IQ_FLUSH_EN  when defined, adds the iq_flush port and its flush logic.

`ifndef Inst_Width
`define Inst_Width 32
`endif
`ifndef Inst_Addr_Width
`define Inst_Addr_Width 32
`endif

module inst_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef IQ_FLUSH_EN
  input  logic                        iq_flush,
`endif
  input  logic                        fetch_valid,
  input  logic [`Inst_Width-1:0]      fetch_inst,
  input  logic [`Inst_Addr_Width-1:0] fetch_pc,
  output logic                        fetch_ready,
  output logic [`Inst_Width-1:0]      inst_in,
  output logic [`Inst_Addr_Width-1:0] inst_pc,
  output logic                        inst_stall,
  input  logic                        inst_enable,
  output logic [DEPTH_LOG2:0]         iq_count
);

  localparam int                  Depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCount = (DEPTH_LOG2+1)'(Depth);
  localparam logic [DEPTH_LOG2:0] CountOne   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = DEPTH_LOG2'(1);

  // Entry storage. It is never reset, because the count decides validity.
  logic [`Inst_Width-1:0]      inst_mem_q [Depth];
  logic [`Inst_Addr_Width-1:0] pc_mem_q   [Depth];

  logic [DEPTH_LOG2-1:0] head_q, head_d;
  logic [DEPTH_LOG2-1:0] tail_q, tail_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  logic push;
  logic pop;
  logic flush;
  logic wr_en;

  // A flush clears the queue in one edge. Without the feature it is tied low.
`ifdef IQ_FLUSH_EN
  assign flush = iq_flush;
`else
  assign flush = 1'b0;
`endif

  // Handshake status comes only from the registered count. As a result,
  // fetch_ready never depends on inst_enable in the same cycle.
  always_comb begin
    fetch_ready = (count_q != DepthCount);
    inst_stall  = (count_q == '0);
    push        = fetch_valid & fetch_ready;
    pop         = inst_enable & ~inst_stall;
    wr_en       = push & ~flush;
  end

  // Next-state pointers and count. The pointers are exactly DEPTH_LOG2 bits
  // wide, so the increment wraps modulo depth. When push and pop happen
  // together, the count is unchanged. A flush overrides both.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d = head_q + PtrOne;
      end
      if (push) begin
        tail_d = tail_q + PtrOne;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers. Reset acts at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write at the tail. A flushed push is not written, so the
  // dropped instruction never lands in the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem_q[tail_q] <= fetch_inst;
      pc_mem_q[tail_q]   <= fetch_pc;
    end
  end

  // The head is presented with zero latency. The outputs are forced to zero
  // when the queue is empty, so stale array contents never reach decode.
  always_comb begin
    iq_count = count_q;
    inst_in  = '0;
    inst_pc  = '0;
    if (!inst_stall) begin
      inst_in = inst_mem_q[head_q];
      inst_pc = pc_mem_q[head_q];
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue -- self-checking bench for inst_queue.
//
// A reference model treats the queue as an ordered list of {inst, pc} words.
// Each edge accepts a push when the list holds fewer than 8 entries and a
// pop when it is non-empty. After every edge, all DUT outputs are compared
// with the model. Directed scenarios are followed by a randomized run.
// Defining IQ_FLUSH_EN enables the flush scenario.

`ifndef Inst_Width
`define Inst_Width 32
`endif
`ifndef Inst_Addr_Width
`define Inst_Addr_Width 32
`endif

module tb_inst_queue;

  localparam int Depth = 8;

  logic                        clk;
  logic                        rst;
  logic                        iq_flush;
  logic                        fetch_valid;
  logic [`Inst_Width-1:0]      fetch_inst;
  logic [`Inst_Addr_Width-1:0] fetch_pc;
  logic                        fetch_ready;
  logic [`Inst_Width-1:0]      inst_in;
  logic [`Inst_Addr_Width-1:0] inst_pc;
  logic                        inst_stall;
  logic                        inst_enable;
  logic [3:0]                  iq_count;

  // Reference model: the front of the queue is the entry that decode sees.
  logic [63:0] modelQ[$];

  int compared;
  int mismatched;

  inst_queue #(.DEPTH_LOG2(3)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef IQ_FLUSH_EN
    .iq_flush    (iq_flush),
`endif
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .inst_in     (inst_in),
    .inst_pc     (inst_pc),
    .inst_stall  (inst_stall),
    .inst_enable (inst_enable),
    .iq_count    (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Compares every DUT output with the model's view of the queue.
  task automatic checkState(input string tag);
    logic [63:0] headWord;
    headWord = (modelQ.size() > 0) ? modelQ[0] : 64'd0;
    checkOutput({tag, ".count"}, 64'(iq_count), 64'(modelQ.size()));
    checkOutput({tag, ".stall"}, 64'(inst_stall), 64'(modelQ.size() == 0));
    checkOutput({tag, ".ready"}, 64'(fetch_ready), 64'(modelQ.size() != Depth));
    checkOutput({tag, ".inst"}, 64'(inst_in), 64'(headWord[63:32]));
    checkOutput({tag, ".pc"}, 64'(inst_pc), 64'(headWord[31:0]));
  endtask

  // Drives one cycle of inputs from a falling edge and advances the model at
  // the rising edge. The outputs are then checked at the next falling edge.
  task automatic applyStimulus(input string tag, input logic fv,
                               input logic [31:0] inst, input logic [31:0] pc,
                               input logic en, input logic fl);
    bit doPush;
    bit doPop;
    fetch_valid = fv;
    fetch_inst  = inst;
    fetch_pc    = pc;
    inst_enable = en;
    iq_flush    = fl;
    @(posedge clk);
    if (fl) begin
      modelQ.delete();
    end else begin
      doPush = fv && (modelQ.size() < Depth);
      doPop  = en && (modelQ.size() > 0);
      if (doPop)  void'(modelQ.pop_front());
      if (doPush) modelQ.push_back({inst, pc});
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    inst_enable = 1'b0;
    iq_flush    = 1'b0;
    checkState(tag);
  endtask

  task automatic doReset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelQ.delete();
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    iq_flush    = 1'b0;
    fetch_valid = 1'b0;
    fetch_inst  = '0;
    fetch_pc    = '0;
    inst_enable = 1'b0;
    @(negedge clk);
    doReset();
    checkState("reset");

    // Three pushes without pops.
    for (int i = 0; i < 3; i++)
      applyStimulus("fill3", 1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
    checkOutput("fill3.pc0", 64'(inst_pc), 64'h0);

    // Fill to full, then offer a ninth instruction, which must be dropped.
    doReset();
    for (int i = 0; i < Depth; i++)
      applyStimulus("full", 1'b1, 32'hA000 + 32'(i), 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    checkOutput("full.ready", 64'(fetch_ready), 64'h0);
    applyStimulus("ninth", 1'b1, 32'hDEAD, 32'hBAD0, 1'b0, 1'b0);
    checkOutput("ninth.count", 64'(iq_count), 64'd8);
    // Full with both valid and enable set: only the pop happens.
    applyStimulus("fullboth", 1'b1, 32'hBEEF, 32'hBAD4, 1'b1, 1'b0);
    checkOutput("fullboth.count", 64'(iq_count), 64'd7);
    for (int i = 0; i < Depth - 1; i++)
      applyStimulus("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain.inst0", 64'(inst_in), 64'h0);
    // A pop while empty must be ignored.
    applyStimulus("popempty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Steady push+pop with count 4 makes the pointers wrap.
    for (int i = 0; i < 4; i++)
      applyStimulus("pre4", 1'b1, 32'hB000 + 32'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus("steady", 1'b1, 32'hC000 + 32'(i), 32'h300 + 32'(i * 4), 1'b1, 1'b0);
    checkOutput("steady.count", 64'(iq_count), 64'd4);
    for (int i = 0; i < 4; i++)
      applyStimulus("drain4", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Empty queue with push and pop together: only the push happens.
    applyStimulus("emptyboth", 1'b1, 32'h7777, 32'h444, 1'b1, 1'b0);
    checkOutput("emptyboth.count", 64'(iq_count), 64'd1);
    checkOutput("emptyboth.pc", 64'(inst_pc), 64'h444);
    applyStimulus("drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with 5 entries queued.
    for (int i = 0; i < 5; i++)
      applyStimulus("pre5", 1'b1, 32'hD000 + 32'(i), 32'h500 + 32'(i * 4), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    modelQ.delete();
    checkState("asyncrst");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus("postrst", 1'b1, 32'hE000, 32'h600, 1'b0, 1'b0);
    applyStimulus("postrst2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef IQ_FLUSH_EN
    // Flush with 6 entries, overriding a same-cycle push and pop.
    for (int i = 0; i < 6; i++)
      applyStimulus("pre6", 1'b1, 32'hF000 + 32'(i), 32'h700 + 32'(i * 4), 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 32'hFFFF, 32'h7FC, 1'b1, 1'b1);
    checkOutput("flush.count", 64'(iq_count), 64'd0);
    checkOutput("flush.stall", 64'(inst_stall), 64'd1);
    applyStimulus("postflush", 1'b1, 32'h1234, 32'h800, 1'b0, 1'b0);
    checkOutput("postflush.pc", 64'(inst_pc), 64'h800);
`endif

    // Randomized traffic with varying push/pop pressure.
    for (int i = 0; i < 400; i++) begin
      int bias;
      logic fv;
      logic en;
      bias = (i / 100) % 2;
      fv = ($urandom_range(0, 99) < (bias ? 75 : 40));
      en = ($urandom_range(0, 99) < (bias ? 40 : 75));
`ifdef IQ_FLUSH_EN
      applyStimulus("rand", fv, $urandom, $urandom, en, $urandom_range(0, 49) == 0);
`else
      applyStimulus("rand", fv, $urandom, $urandom, en, 1'b0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
